// File: rtl/spi_rx_deser.sv
// SPI master-side receive deserializer: shifts SPI_MISO into a DATA_WIDTH-bit word
// per frame and hands it to the controller through a valid/ack handshake with overrun flag.
module spi_rx_deser #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter bit          MSB_FIRST  = 1'b1
) (
  input  logic                  spi_clk,
  input  logic                  reset,
  input  logic                  SPI_MISO,
  input  logic                  rx_load,
  input  logic                  rx_ack,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  rx_busy,
  output logic                  rx_overrun
);

  localparam int unsigned  CW   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  ovr_q, ovr_d;

  logic                  sample;
  logic                  complete;
  logic [DATA_WIDTH-1:0] shift_in;

  always_ff @(posedge spi_clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rx_load) state_d = SHIFT;
      SHIFT:   if (cnt_q == LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rx_busy = (state_q == SHIFT);
  end

  // The start edge already samples bit 0, so sampling happens in IDLE with rx_load too.
  always_comb begin
    sample   = (state_q == SHIFT) || ((state_q == IDLE) && rx_load);
    complete = (state_q == SHIFT) && (cnt_q == LAST);
    if (MSB_FIRST) shift_in = {shift_q[DATA_WIDTH-2:0], SPI_MISO};
    else           shift_in = {SPI_MISO, shift_q[DATA_WIDTH-1:1]};

    cnt_d   = cnt_q;
    shift_d = shift_q;
    if (sample) begin
      shift_d = shift_in;
      cnt_d   = complete ? '0 : cnt_q + CW'(1);
    end

    data_d  = complete ? shift_in : data_q;
    valid_d = complete | (valid_q & ~rx_ack);

    // An ack on the completion edge consumes the old word, so no overrun then.
    ovr_d = ovr_q;
    if (complete && valid_q && !rx_ack) ovr_d = 1'b1;
    else if (valid_q && rx_ack)         ovr_d = 1'b0;
  end

  always_ff @(posedge spi_clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    rx_data    = data_q;
    rx_valid   = valid_q;
    rx_overrun = ovr_q;
  end

endmodule

// File: tb/tb_spi_rx_deser.sv
// Directed bench for spi_rx_deser: one MSB-first and one LSB-first instance share stimulus.
module tb_spi_rx_deser;

  logic       clk;
  logic       rst_n;
  logic       miso;
  logic       load;
  logic       ack;
  logic [7:0] data_m, data_l;
  logic       valid_m, valid_l, busy_m, busy_l, ovr_m, ovr_l;

  int unsigned vectors;
  int unsigned miscompares;

  spi_rx_deser #(.DATA_WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .spi_clk(clk), .reset(rst_n), .SPI_MISO(miso), .rx_load(load), .rx_ack(ack),
    .rx_data(data_m), .rx_valid(valid_m), .rx_busy(busy_m), .rx_overrun(ovr_m)
  );

  spi_rx_deser #(.DATA_WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .spi_clk(clk), .reset(rst_n), .SPI_MISO(miso), .rx_load(load), .rx_ack(ack),
    .rx_data(data_l), .rx_valid(valid_l), .rx_busy(busy_l), .rx_overrun(ovr_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] stream;      // stream[7] is the first bit on the wire
    logic       toggle_load; // wiggle rx_load during SHIFT
    logic       ack_last;    // rx_ack on the completion edge
    logic       ack_after;   // rx_ack pulse on the edge after completion
    logic [7:0] exp_m;
    logic [7:0] exp_l;
    logic       exp_ovr;
  } vec_t;

  vec_t tbl[6];
  vec_t rst_frame;

  // Packed view: {data_m, data_l, valid_m, valid_l, busy_m, busy_l, ovr_m, ovr_l}
  function automatic logic [21:0] outs();
    return {data_m, data_l, valid_m, valid_l, busy_m, busy_l, ovr_m, ovr_l};
  endfunction

  function automatic logic [21:0] exp_outs(input logic [7:0] dm, input logic [7:0] dl,
                                           input logic v, input logic b, input logic o);
    return {dm, dl, v, v, b, b, o, o};
  endfunction

  task automatic check(input string name, input logic [21:0] got, input logic [21:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (data_m,data_l,vm,vl,bm,bl,om,ol)", name, got, exp);
    end
  endtask

  task automatic cyc(input logic l, input logic a, input logic m);
    @(negedge clk);
    load = l;
    ack  = a;
    miso = m;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input string name, input vec_t v);
    logic [7:0] s;
    s = v.stream;
    cyc(1'b1, 1'b0, s[7]);
    vectors++;
    if (busy_m !== 1'b1 || busy_l !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_busy: got %b%b expected 11", name, busy_m, busy_l);
    end
    for (int i = 1; i < 8; i++)
      cyc(v.toggle_load ? logic'(i % 2) : 1'b0, (i == 7) ? v.ack_last : 1'b0, s[7-i]);
    check({name, "_done"}, outs(), exp_outs(v.exp_m, v.exp_l, 1'b1, 1'b0, v.exp_ovr));
    if (v.ack_after) begin
      cyc(1'b0, 1'b1, 1'b0);
      check({name, "_ack"}, outs(), exp_outs(v.exp_m, v.exp_l, 1'b0, 1'b0, 1'b0));
    end
    @(negedge clk);
    load = 1'b0;
    ack  = 1'b0;
  endtask

  initial begin
    logic [15:0] cw;
    vectors     = 0;
    miscompares = 0;

    //          stream  tog   ackL  ackA  exp_m  exp_l  ovr
    tbl[0] = '{8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 8'hA5, 1'b0};
    tbl[1] = '{8'hC0, 1'b1, 1'b0, 1'b1, 8'hC0, 8'h03, 1'b0};
    tbl[2] = '{8'h11, 1'b0, 1'b0, 1'b0, 8'h11, 8'h88, 1'b0};
    tbl[3] = '{8'h22, 1'b0, 1'b0, 1'b1, 8'h22, 8'h44, 1'b1};
    tbl[4] = '{8'h3C, 1'b1, 1'b0, 1'b0, 8'h3C, 8'h3C, 1'b0};
    tbl[5] = '{8'hC3, 1'b0, 1'b1, 1'b1, 8'hC3, 8'hC3, 1'b0};
    rst_frame = '{8'h5A, 1'b0, 1'b0, 1'b0, 8'h5A, 8'h5A, 1'b0};

    rst_n = 1'b0;
    load  = 1'b0;
    ack   = 1'b0;
    miso  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset", outs(), '0);
    @(negedge clk);
    rst_n = 1'b1;

    cyc(1'b0, 1'b1, 1'b1);
    check("ack_when_empty", outs(), '0);

    for (int r = 0; r < 6; r++)
      send_frame($sformatf("tbl%0d", r), tbl[r]);

    // Continuous rx_load: completions exactly at edges 7 and 15, no gap.
    cw = 16'h3CC3;
    for (int e = 0; e < 16; e++) begin
      cyc(1'b1, (e == 8) ? 1'b1 : 1'b0, cw[15-e]);
      if (e == 6)  check("cont_e6",  outs(), exp_outs(8'hC3, 8'hC3, 1'b0, 1'b1, 1'b0));
      if (e == 7)  check("cont_e7",  outs(), exp_outs(8'h3C, 8'h3C, 1'b1, 1'b0, 1'b0));
      if (e == 8)  check("cont_e8",  outs(), exp_outs(8'h3C, 8'h3C, 1'b0, 1'b1, 1'b0));
      if (e == 15) check("cont_e15", outs(), exp_outs(8'hC3, 8'hC3, 1'b1, 1'b0, 1'b0));
    end
    cyc(1'b0, 1'b1, 1'b0);
    check("cont_ack", outs(), exp_outs(8'hC3, 8'hC3, 1'b0, 1'b0, 1'b0));

    // Mid-frame asynchronous reset after four bits of 0x5A.
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    check("mid_busy", outs(), exp_outs(8'hC3, 8'hC3, 1'b0, 1'b1, 1'b0));
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset", outs(), '0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    check("post_reset_idle", outs(), '0);
    send_frame("after_reset", rst_frame);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
